gate_selftest_ctrl: RTL and testbench

- Sequencer that drives a 2-input combinational gate (and2 by default) through all four input vectors, waits a programmable settle time, samples the gate output and compares it against an expected truth table.
- Reports per-vector failures and an overall pass flag.
- Sits beside the gate under test as its built-in self-test controller, replacing hand-written stimulus sequences.

---
 rtl/gate_test_pkg.sv | 40 ++++
 rtl/gate_selftest_ctrl.sv | 166 ++++++++++++++++
 tb/tb_gate_selftest_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// ---------------------------------------------------------------------------
// gate_test_pkg
// Shared types and constants for the 2-input gate self-test controller.
//   state_t  : sequencer states
//   NUM_VEC  : number of input vectors a 2-input gate has
//   vec_of() : maps a sequence position to the {a,b} vector applied there
//   *_TT     : expected truth tables, bit index = {a,b}
// ---------------------------------------------------------------------------
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 4;

  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] OR2_TT   = 4'b1110;
  localparam logic [3:0] XOR2_TT  = 4'b0110;
  localparam logic [3:0] NAND2_TT = 4'b0111;

  // Vectors are walked in Gray order so only one gate input toggles per
  // step, which keeps the gate from seeing a two-input glitch between vectors.
  function automatic logic [1:0] vec_of(input logic [1:0] idx);
    logic [1:0] vec;
    vec = 2'b00;
    case (idx)
      2'd0: vec = 2'b00;
      2'd1: vec = 2'b01;
      2'd2: vec = 2'b11;
      2'd3: vec = 2'b10;
      default: vec = 2'b00;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/gate_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// gate_selftest_ctrl
// Built-in self-test sequencer for a 2-input combinational gate. On start it
// applies the four input vectors in Gray order, holds each for SETTLE_CYCLES
// cycles, samples the gate output for one cycle and compares it with the
// EXPECT truth table. Mismatching vectors are collected in o_fail_mask.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
//   EXPECT        : expected truth table, bit index = {a,b}
//
// Ports
//   i_clk        : rising-edge clock
//   i_reset      : asynchronous active-high reset
//   i_start      : begin a run (honoured only in IDLE or DONE)
//   i_abort      : cancel any run, return to IDLE with results cleared
//   o_a, o_b     : gate inputs
//   i_y          : gate output
//   o_busy       : high in SETTLE and SAMPLE
//   o_done       : high in DONE until next start, abort or reset
//   o_pass       : done with no mismatching vector
//   o_fail_mask  : bit {a,b} set if that vector mismatched
//   o_vector_idx : sequence position of the vector currently applied
// ---------------------------------------------------------------------------
module gate_selftest_ctrl
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = AND2_TT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_a,
  output logic       o_b,
  input  logic       i_y,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask,
  output logic [1:0] o_vector_idx
);

  // Terminal count of the settle counter; the vector is held for
  // SETTLE_CYCLES cycles in SETTLE before the one SAMPLE cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX    = 2'(NUM_VEC - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_failMask;
  logic [1:0] r_vectorIdx;

  logic [1:0] w_curVec;
  logic       w_mismatch;
  logic [3:0] w_failNext;
  logic [1:0] w_nextIdx;
  logic [1:0] w_nextVec;
  logic [1:0] w_firstVec;
  logic       w_lastVec;

  // Result bookkeeping for the SAMPLE cycle. The mismatch is folded into the
  // mask here so the registered pass flag can be computed from the mask value
  // that is being written on the same edge, rather than one cycle late.
  assign w_curVec   = {r_a, r_b};
  assign w_mismatch = (i_y != EXPECT[w_curVec]);
  assign w_failNext = r_failMask | (w_mismatch ? (4'b0001 << w_curVec) : 4'b0000);
  assign w_nextIdx  = r_vectorIdx + 2'd1;
  assign w_nextVec  = vec_of(w_nextIdx);
  assign w_firstVec = vec_of(2'd0);
  assign w_lastVec  = (r_vectorIdx == LAST_IDX);

  // Single sequencer: state, settle counter, gate drive and all result
  // outputs are registered together so nothing reaches an output
  // combinationally from i_y. Abort outranks start and every state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_failMask  <= 4'd0;
      r_vectorIdx <= 2'd0;
    end else if (i_abort) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_failMask  <= 4'd0;
      r_vectorIdx <= 2'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // A restart from DONE behaves exactly like a start from IDLE,
          // including wiping the previous run's results.
          if (i_start) begin
            r_state     <= SETTLE;
            r_cnt       <= 4'd0;
            {r_a, r_b}  <= w_firstVec;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_failMask  <= 4'd0;
            r_vectorIdx <= 2'd0;
          end else begin
            r_a <= 1'b0;
            r_b <= 1'b0;
          end
        end

        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        SAMPLE: begin
          r_failMask <= w_failNext;
          if (w_lastVec) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_failNext == 4'd0);
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end else begin
            r_state     <= SETTLE;
            r_cnt       <= 4'd0;
            r_vectorIdx <= w_nextIdx;
            {r_a, r_b}  <= w_nextVec;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
      endcase
    end
  end

  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail_mask  = r_failMask;
  assign o_vector_idx = r_vectorIdx;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gate_selftest_ctrl
// Scoreboard bench for gate_selftest_ctrl. Two instances: the main one
// expects an AND gate with the default settle time, the second expects an
// OR truth table with the minimum settle time while driven by a real AND.
// Stimulus pushes expected vector sequences and final results into queues;
// monitors on the falling edge pop and compare whenever the DUT is busy or
// raises done.
// ---------------------------------------------------------------------------
module tb_gate_selftest_ctrl;
  import gate_test_pkg::*;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
    int         latency;
  } result_t;

  // Expected {vector_idx, a, b} per sequence position, hand-written.
  localparam logic [3:0] SEQ_TABLE [4] = '{4'b0000, 4'b0101, 4'b1011, 4'b1110};

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic abort;
  logic a, b, y, busy, done, pass;
  logic [3:0] failMask;
  logic [1:0] vecIdx;

  logic start2;
  logic abort2;
  logic a2, b2, y2, busy2, done2, pass2;
  logic [3:0] failMask2;
  logic [1:0] vecIdx2;

  int cycle       = 0;
  int startCycle  = 0;
  int startCycle2 = 0;
  int gateMode    = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  result_t    expQ[$];
  result_t    expQ2[$];
  logic [3:0] seqQ[$];

  logic donePrev  = 1'b0;
  logic donePrev2 = 1'b0;

  // Gate models: 0 = real and2, 1 = output stuck at 0, 2 = and2 that is only
  // correct in the cycle before each sampling edge and inverted otherwise.
  assign y = (gateMode == 0) ? (a & b) :
             (gateMode == 1) ? 1'b0 :
             ((((cycle - startCycle) % 3) == 2) ? (a & b) : ~(a & b));
  assign y2 = a2 & b2;
  assign abort2 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  gate_selftest_ctrl #(.SETTLE_CYCLES(2), .EXPECT(AND2_TT)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
    .o_a(a), .o_b(b), .i_y(y), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_fail_mask(failMask), .o_vector_idx(vecIdx)
  );

  gate_selftest_ctrl #(.SETTLE_CYCLES(1), .EXPECT(OR2_TT)) dutOr (
    .i_clk(clk), .i_reset(reset), .i_start(start2), .i_abort(abort2),
    .o_a(a2), .o_b(b2), .i_y(y2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_fail_mask(failMask2), .o_vector_idx(vecIdx2)
  );

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s", name);
  endtask

  // Monitor for the main instance: every busy cycle must show the next
  // expected vector, and every rising done must match the next result.
  always @(negedge clk) begin
    result_t  e;
    logic [3:0] s;
    if (busy === 1'b1) begin
      if (seqQ.size() == 0) begin
        flagFail("unexpected busy cycle");
      end else begin
        s = seqQ.pop_front();
        checkOutput("vector {idx,a,b}", {28'd0, vecIdx, a, b}, {28'd0, s});
      end
    end
    if (done === 1'b1 && donePrev !== 1'b1) begin
      if (expQ.size() == 0) begin
        flagFail("unexpected done");
      end else begin
        e = expQ.pop_front();
        checkOutput("fail_mask", {28'd0, failMask}, {28'd0, e.mask});
        checkOutput("pass", {31'd0, pass}, {31'd0, e.pass});
        checkOutput("done latency", cycle - startCycle, e.latency);
      end
    end
    donePrev = done;
  end

  // Monitor for the OR-expecting instance.
  always @(negedge clk) begin
    result_t e;
    if (done2 === 1'b1 && donePrev2 !== 1'b1) begin
      if (expQ2.size() == 0) begin
        flagFail("unexpected done (or inst)");
      end else begin
        e = expQ2.pop_front();
        checkOutput("fail_mask (or inst)", {28'd0, failMask2}, {28'd0, e.mask});
        checkOutput("pass (or inst)", {31'd0, pass2}, {31'd0, e.pass});
        checkOutput("done latency (or inst)", cycle - startCycle2, e.latency);
      end
    end
    donePrev2 = done2;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Queues seqLen expected vector samples (and optionally a final result),
  // then pulses start for one edge. Returns just after the start edge.
  task automatic applyStimulus(input int mode, input logic [3:0] expMask,
                               input logic expPass, input int seqLen,
                               input bit pushResult);
    result_t r;
    gateMode = mode;
    for (int k = 0; k < seqLen; k++) seqQ.push_back(SEQ_TABLE[k / 3]);
    if (pushResult) begin
      r.mask    = expMask;
      r.pass    = expPass;
      r.latency = 12;
      expQ.push_back(r);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    startCycle = cycle;
    start = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (expQ.size() == 0 && expQ2.size() == 0 && seqQ.size() == 0) break;
      tick();
    end
    if (expQ.size() != 0 || expQ2.size() != 0 || seqQ.size() != 0) begin
      flagFail({name, " timed out waiting for DUT"});
      expQ.delete();
      expQ2.delete();
      seqQ.delete();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    result_t r2;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("reset a", {31'd0, a}, 32'd0);
    checkOutput("reset b", {31'd0, b}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset pass", {31'd0, pass}, 32'd0);
    checkOutput("reset fail_mask", {28'd0, failMask}, 32'd0);
    checkOutput("reset vector_idx", {30'd0, vecIdx}, 32'd0);
    checkOutput("reset done (or inst)", {31'd0, done2}, 32'd0);
    reset = 1'b0;
    tick();

    // Good AND gate: clean pass, then done held in DONE with gate idle.
    applyStimulus(0, 4'b0000, 1'b1, 12, 1'b1);
    waitDrain("good run");
    tick();
    tick();
    checkOutput("done held", {31'd0, done}, 32'd1);
    checkOutput("pass held", {31'd0, pass}, 32'd1);
    checkOutput("busy in DONE", {31'd0, busy}, 32'd0);
    checkOutput("a,b in DONE", {30'd0, a, b}, 32'd0);

    // Stuck-at-0 gate: only vector 11 fails.
    applyStimulus(1, 4'b1000, 1'b0, 12, 1'b1);
    waitDrain("stuck run");
    checkOutput("stuck fail_mask held", {28'd0, failMask}, 32'h8);

    // Restart from DONE after a failing run clears the mask on the start edge.
    applyStimulus(0, 4'b0000, 1'b1, 12, 1'b1);
    checkOutput("mask cleared on restart", {28'd0, failMask}, 32'd0);
    checkOutput("done cleared on restart", {31'd0, done}, 32'd0);
    checkOutput("busy after restart", {31'd0, busy}, 32'd1);
    waitDrain("restart run");

    // y garbage outside the sampling cycle must not affect the result.
    applyStimulus(2, 4'b0000, 1'b1, 12, 1'b1);
    waitDrain("glitchy-y run");

    // start re-pulsed while busy: sequence and latency unchanged.
    applyStimulus(0, 4'b0000, 1'b1, 12, 1'b1);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDrain("start-while-busy run");

    // Abort during the second settle period, then a clean run.
    applyStimulus(1, 4'b0000, 1'b0, 4, 1'b0);
    repeat (4) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort a,b", {30'd0, a, b}, 32'd0);
    checkOutput("abort fail_mask", {28'd0, failMask}, 32'd0);
    tick();
    checkOutput("abort stays idle", {31'd0, busy}, 32'd0);
    applyStimulus(0, 4'b0000, 1'b1, 12, 1'b1);
    waitDrain("post-abort run");

    // Async reset between edges during the last SAMPLE.
    applyStimulus(1, 4'b0000, 1'b0, 11, 1'b0);
    repeat (11) tick();
    @(posedge clk);
    #2;
    checkOutput("mask before reset", {28'd0, failMask}, 32'h8);
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset a,b", {30'd0, a, b}, 32'd0);
    checkOutput("async reset fail_mask", {28'd0, failMask}, 32'd0);
    checkOutput("async reset vector_idx", {30'd0, vecIdx}, 32'd0);
    checkOutput("async reset done", {31'd0, done}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    if (seqQ.size() != 0) begin
      flagFail("vector samples left after reset");
      seqQ.delete();
    end
    applyStimulus(0, 4'b0000, 1'b1, 12, 1'b1);
    waitDrain("post-reset run");

    // OR truth table against a real AND, minimum settle time.
    r2.mask    = 4'b0110;
    r2.pass    = 1'b0;
    r2.latency = 8;
    expQ2.push_back(r2);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    startCycle2 = cycle;
    start2 = 1'b0;
    waitDrain("or-expect run");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
